// File: rtl/sub_bytes_seq_if.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq_if
// Handshake bundle for the iterative SubBytes stage.
//   in_valid / in_ready / in_state    : upstream state transfer (AddRoundKey side)
//   out_valid / out_ready / out_state : downstream result transfer (ShiftRows side)
//   busy                              : stage is working on or holding a block
// Modports:
//   master : the side that supplies states and consumes results
//   slave  : the sub_bytes_seq block itself
// -----------------------------------------------------------------------------
interface sub_bytes_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    modport master (
        output in_valid,
        output in_state,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_state,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state,
        output busy
    );
endinterface

// File: rtl/sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// sub_bytes_seq
// Iterative AES SubBytes for a 128-bit round state. A state is accepted over
// the input handshake, BYTES_PER_CYCLE bytes are substituted per clock through
// that many s_box instances, and the result is offered on the output handshake.
//
// Parameters:
//   BYTES_PER_CYCLE : s_box instances / bytes per clock (1, 2, 4, 8 or 16)
// Ports:
//   clk   : system clock, rising edge
//   n_rst : synchronous active-low reset
//   bus   : sub_bytes_seq_if.slave (in_valid/in_ready/in_state,
//           out_valid/out_ready/out_state, busy)
// Byte order: AES byte i = state[127-8i -: 8], column-major (row i%4, col i/4).
// Build option:
//   SUB_BYTES_SHIFT_ROWS_EN : when defined, out_state is the ShiftRows
//   permutation of the result register (SubBytes followed by ShiftRows).
// -----------------------------------------------------------------------------

// FIPS-197 forward S-box, computed as multiplicative inverse in GF(2^8)
// (x^254, which also maps 0 to 0) followed by the affine transform.
module s_box (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    always_comb begin
        inv = 8'h01;
        sq  = in_byte;
        // inv accumulates x^2 * x^4 * ... * x^128 = x^254
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_byte = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end
endmodule

module sub_bytes_seq #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    sub_bytes_seq_if.slave bus
);
    localparam int N_CHUNKS = 16 / BYTES_PER_CYCLE;
    // A single-chunk build still needs a one-bit counter to have a legal vector.
    localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       data_q, data_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [7:0]         byte_q   [16];
    logic [7:0]         sub_in   [BYTES_PER_CYCLE];
    logic [7:0]         sub_out  [BYTES_PER_CYCLE];
    logic [127:0]       sub_data;
    logic [3:0]         chunk_base;
    logic [127:0]       out_perm;

    // Byte view of the data register in AES byte order.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
            assign byte_q[gi] = data_q[127-8*gi -: 8];
        end
    endgenerate

    assign chunk_base = 4'(int'(cnt_q) * BYTES_PER_CYCLE);

    // Each s_box serves the same lane of every chunk; the counter selects the chunk.
    generate
        for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
            assign sub_in[gi] = byte_q[chunk_base + 4'(gi)];
            s_box u_s_box (
                .in_byte  (sub_in[gi]),
                .out_byte (sub_out[gi])
            );
        end
    endgenerate

    // Register image after this cycle's substitution: only the active chunk changes.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_merge
            assign sub_data[127-8*gi -: 8] = (CNT_W'(gi / BYTES_PER_CYCLE) == cnt_q)
                                           ? sub_out[gi % BYTES_PER_CYCLE]
                                           : byte_q[gi];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    data_d  = bus.in_state;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end
            SUB: begin
                data_d = sub_data;
                if (cnt_q == CNT_W'(N_CHUNKS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // The result stays in the register; it simply stops being offered.
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered images of the next state, so in_ready
        // only returns the cycle after the result has been taken.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef SUB_BYTES_SHIFT_ROWS_EN
    // ShiftRows: output byte (r + 4c) takes result byte (r + 4*((c + r) mod 4)).
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_shift_rows
            localparam int R = gi % 4;
            localparam int C = gi / 4;
            assign out_perm[127-8*gi -: 8] = data_q[127-8*(R + 4*((C + R) % 4)) -: 8];
        end
    endgenerate
`else
    assign out_perm = data_q;
`endif

    assign bus.out_state = out_perm;
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Iterative AES SubBytes stage for the 128-bit round datapath.
- Accepts one 128-bit state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through that many instances of the team's s_box lookup (8-bit in, 8-bit out, combinational).
- Returns the substituted state over a second valid/ready handshake.
- Sits between AddRoundKey (upstream) and ShiftRows/MixColumns (downstream); trades area for latency against a 16-s_box combinational SubBytes.

Parameters:
- BYTES_PER_CYCLE, 4: s_box instances and bytes substituted per clock.
  - Legal values: 1, 2, 4, 8, 16. Any other value is a elaboration error.
- Derived N_CHUNKS = 16 / BYTES_PER_CYCLE: cycles per block.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  synchronous, active-low reset; sampled on rising clk.
- in_valid  input  1  upstream state valid.
- in_ready  output  1  block can accept a state.
- in_state  input  128  state; AES byte i = in_state[127-8i -: 8], column-major (byte i = row i%4, column i/4).
- out_valid  output  1  out_state holds a completed result.
- out_ready  input  1  downstream accepts result.
- out_state  output  128  substituted state, same byte ordering.
- busy  output  1  high in SUB or DONE.

Behaviour:
- Reset (n_rst=0 at a rising edge):
  - state -> IDLE; chunk counter -> 0; data register -> 0.
  - in_ready=1, out_valid=0, busy=0, out_state=128'h0.
  - Applies mid-operation: any in-flight block is discarded, no output produced.
- Registered state: one 128-bit data register (holds the input, then the result); log2(N_CHUNKS)-bit chunk counter; FSM {IDLE, SUB, DONE}.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: capture in_state into data register, counter <- 0, go to SUB.
- SUB:
  - in_ready=0, busy=1.
  - Each edge replaces bytes [cnt*BPC .. cnt*BPC+BPC-1] of the data register with their s_box values; counter increments.
  - On the edge where cnt = N_CHUNKS-1: counter wraps to 0, go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - out_state = data register (through the optional permutation), held stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE, data register unchanged.
- Latency:
  - Input handshake at edge k; out_valid is high after edge k+N_CHUNKS (4 cycles at default).
  - Minimum issue interval is N_CHUNKS+2 cycles: one DONE cycle plus one IDLE bubble.
  - in_ready is never asserted in DONE, even if out_ready=1 in the same cycle.
- out_state is driven from the register only (no combinational path from in_state or out_ready).
  - It reads 0 after reset until the first completion.
  - It is don't-care-stable but defined outside DONE, where it shows the register contents.
- in_valid while in_ready=0 is ignored; upstream must hold its data.
- in_state is sampled only at the accept edge; later changes have no effect.
- s_box mapping is exactly the FIPS-197 forward S-box (0x00->0x63, 0xff->0x16).

Optional Feature:
- Macro: SUB_BYTES_SHIFT_ROWS_EN.
- Defined: out_state applies AES ShiftRows combinationally on the register output.
  - Output byte (r + 4c) = result byte (r + 4*((c + r) mod 4)).
  - The block performs SubBytes followed by ShiftRows; latency is unchanged.
- Undefined: out_state = register contents unpermuted (SubBytes only).

Test Plan:
- Reset then idle: n_rst=0 for 2 cycles -> in_ready=1, out_valid=0, busy=0, out_state=0.
- in_state=128'h0, out_ready=1 -> out_valid rises exactly 4 cycles after accept.
  - out_state=128'h6363...63 (16 bytes), with or without the macro.
- FIPS-197 App. B round 1, in_state=193de3bea0f4e22b9ac68d2ae9f84808:
  - Without macro -> d42711aee0bf98f1b8b45de51e415230.
  - With macro -> d4bf5d30e0b452aeb84111f11e2798e5.
- Backpressure: in_state all 0xff, out_ready=0 for 10 cycles.
  - out_valid stays 1, out_state=161616...16 stable, in_ready=0, a new in_valid is ignored.
  - Release out_ready -> one transfer, then in_ready=1 the following cycle.
- Reset mid-op: assert n_rst=0 at the 2nd SUB cycle.
  - Next cycle: IDLE, out_state=0, no out_valid.
  - A fresh block afterwards completes correctly.
- Parameter sweep BYTES_PER_CYCLE in {1,2,8,16}, vector 00112233445566778899aabbccddeeff:
  - Latency = 16, 8, 2, 1 cycles.
  - out_state=638293c31bfc33f5c4eeacea4bc12816 (no macro).
